// File: rtl/game_state_multi.sv
// Flappy game-state controller: parallel bird/pipe collision checks, Initial/Play/Lose
// sequencing with a lose-hold timer, and pass-based scoring with a saturating high score.
module game_state_multi #(
    parameter int NUM_PIPES = 4,
    parameter int W         = 10,
    parameter int SCORE_W   = 8,
    parameter int LOSE_HOLD = 20,
    parameter int CEIL_Y    = 0,
    parameter int FLOOR_Y   = 479
) (
    input  logic                   Clk,
    input  logic                   reset_n,
    input  logic                   Start,
    input  logic                   Ack,
    input  logic [W-1:0]           Bird_X_L,
    input  logic [W-1:0]           Bird_X_R,
    input  logic [W-1:0]           Bird_Y_T,
    input  logic [W-1:0]           Bird_Y_B,
    input  logic [NUM_PIPES-1:0]   Pipe_Valid,
    input  logic [NUM_PIPES*W-1:0] X_Edge_Left,
    input  logic [NUM_PIPES*W-1:0] X_Edge_Right,
    input  logic [NUM_PIPES*W-1:0] Y_Edge_Top,
    input  logic [NUM_PIPES*W-1:0] Y_Edge_Bottom,
    output logic                   Q_Initial,
    output logic                   Q_Play,
    output logic                   Q_Lose,
    output logic [SCORE_W-1:0]     Score,
    output logic [SCORE_W-1:0]     High_Score,
    output logic                   Score_Pulse,
    output logic [NUM_PIPES-1:0]   Hit_Mask
);
    localparam int CNT_W = $clog2(LOSE_HOLD + 1);
    localparam int PC_W  = $clog2(NUM_PIPES + 1);
    localparam int SUM_W = SCORE_W + PC_W;
    localparam logic [CNT_W-1:0]   HOLD_MAX  = CNT_W'(LOSE_HOLD);
    localparam logic [W-1:0]       CEIL_V    = W'(CEIL_Y);
    localparam logic [W-1:0]       FLOOR_V   = W'(FLOOR_Y);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    typedef enum logic [2:0] {
        S_INITIAL = 3'b001,
        S_PLAY    = 3'b010,
        S_LOSE    = 3'b100
    } state_t;

    state_t               state_reg;
    logic [CNT_W-1:0]     hold_cnt_reg;
    logic [NUM_PIPES-1:0] passed_reg;

    logic [NUM_PIPES-1:0] hit;
    logic [NUM_PIPES-1:0] past;
    logic [NUM_PIPES-1:0] new_pass;
    logic [PC_W-1:0]      pass_cnt;
    logic [SUM_W-1:0]     score_sum;
    logic [SCORE_W-1:0]   score_next;
    logic                 boundary_hit;
    logic                 collide;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
            logic [W-1:0] xl, xr, yt, yb;
            logic         overlap_x;
            assign xl = X_Edge_Left[gi*W +: W];
            assign xr = X_Edge_Right[gi*W +: W];
            assign yt = Y_Edge_Top[gi*W +: W];
            assign yb = Y_Edge_Bottom[gi*W +: W];
            assign overlap_x    = Pipe_Valid[gi] && (Bird_X_R > xl) && (Bird_X_L < xr);
            assign hit[gi]      = overlap_x && ((Bird_Y_T < yt) || (Bird_Y_B > yb));
            assign past[gi]     = Pipe_Valid[gi] && (xr <= Bird_X_L);
            assign new_pass[gi] = past[gi] && !passed_reg[gi];
        end
    endgenerate

    always_comb begin
        pass_cnt = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            pass_cnt = pass_cnt + PC_W'(new_pass[i]);
        end
    end

    assign boundary_hit = (Bird_Y_T <= CEIL_V) || (Bird_Y_B >= FLOOR_V);
    assign collide      = (|hit) || boundary_hit;
    assign score_sum    = SUM_W'(Score) + SUM_W'(pass_cnt);
    assign score_next   = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];

    assign {Q_Lose, Q_Play, Q_Initial} = state_reg;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_INITIAL;
            hold_cnt_reg <= '0;
            passed_reg   <= '0;
            Score        <= '0;
            High_Score   <= '0;
            Score_Pulse  <= 1'b0;
            Hit_Mask     <= '0;
        end else begin
            Score_Pulse <= 1'b0;
            // Pass flags follow the pipe position every cycle so recycled pipes re-arm.
            passed_reg  <= past;
            case (state_reg)
                S_INITIAL: begin
                    if (Start) begin
                        state_reg  <= S_PLAY;
                        Score      <= '0;
                        Hit_Mask   <= '0;
                        passed_reg <= '0;
                    end
                end
                S_PLAY: begin
                    if (collide) begin
                        state_reg    <= S_LOSE;
                        Hit_Mask     <= hit;
                        hold_cnt_reg <= '0;
                        if (Score > High_Score) begin
                            High_Score <= Score;
                        end
                    end else if (pass_cnt != '0) begin
                        Score       <= score_next;
                        Score_Pulse <= 1'b1;
                    end
                end
                S_LOSE: begin
                    if (hold_cnt_reg == HOLD_MAX) begin
                        if (Ack) begin
                            state_reg <= S_INITIAL;
                        end
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= S_INITIAL;
            endcase
        end
    end
endmodule

// File: doc/game_state_multi.md
# game_state_multi

Parametrised game-state controller for the Flappy VGA design, sitting between the pipe/bird position generators and the display/score logic. It checks the bird's bounding box against up to NUM_PIPES pipes plus the floor and ceiling every clock. It runs the Initial → Play → Lose state machine with a programmable lose-hold time, and keeps a running score and a high score by detecting when each pipe has been passed.

## Interface
- NUM_PIPES, 4, number of pipe channels checked in parallel (1–8)
- W, 10, coordinate width in bits
- SCORE_W, 8, score and high-score width
- LOSE_HOLD, 20, minimum cycles spent in Lose before Ack is accepted (≥1)
- CEIL_Y, 0, bird top at or above this row is a hit
- FLOOR_Y, 479, bird bottom at or below this row is a hit

Ports:
- Clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- Start  in  1  level; leave Initial
- Ack  in  1  level; leave Lose after hold
- Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B  in  W each  bird box; L<R, T<B, y grows downward
- Pipe_Valid  in  NUM_PIPES  per-pipe enable; invalid pipes are ignored entirely
- X_Edge_Left, X_Edge_Right  in  NUM_PIPES*W  packed; pipe i at bits [i*W +: W]
- Y_Edge_Top, Y_Edge_Bottom  in  NUM_PIPES*W  packed; gap top / gap bottom rows of pipe i
- Q_Initial, Q_Play, Q_Lose  out  1 each  one-hot state
- Score  out  SCORE_W  current score
- High_Score  out  SCORE_W  best score since reset
- Score_Pulse  out  1  one-cycle strobe when Score increments
- Hit_Mask  out  NUM_PIPES  pipes that caused the loss, captured on entry to Lose

## Operation
- States: INITIAL (001), PLAY (010), LOSE (100), encoded {Q_Lose,Q_Play,Q_Initial}. An illegal encoding returns to INITIAL on the next edge.
- INITIAL: when Start=1, go to PLAY. On the same edge, clear Score, Hit_Mask and every passed flag.
- Per pipe i, all comparisons unsigned:
  - overlap_x[i] = Pipe_Valid[i] && Bird_X_R > X_Edge_Left[i] && Bird_X_L < X_Edge_Right[i]
  - hit[i] = overlap_x[i] && (Bird_Y_T < Y_Edge_Top[i] || Bird_Y_B > Y_Edge_Bottom[i])
- Boundary hit = Bird_Y_T <= CEIL_Y || Bird_Y_B >= FLOOR_Y.
- PLAY: if any hit[i] or boundary hit, go to LOSE on that edge. Hit_Mask latches hit[]; it stays 0 for a boundary-only hit.
- Pass detection, per pipe:
  - past[i] = Pipe_Valid[i] && X_Edge_Right[i] <= Bird_X_L
  - passed[i] is set when past[i]=1 and cleared when past[i]=0, so a pipe recycled to the right re-arms.
  - new_pass[i] = past[i] && !passed[i].
- Scoring in PLAY:
  - Score += popcount(new_pass), saturating at 2^SCORE_W−1.
  - Score_Pulse=1 whenever that popcount is nonzero, even if Score is already saturated.
  - A collision in the same cycle has priority: no increment and no pulse, but passed[] still updates.
- LOSE:
  - hold counter resets to 0 on entry, increments each cycle and saturates at LOSE_HOLD.
  - When counter==LOSE_HOLD and Ack=1, go to INITIAL. Earlier Ack is ignored. Start is ignored.
- High_Score: on the edge entering LOSE, if Score > High_Score then High_Score ← Score.
- Score and Hit_Mask hold their values through LOSE and INITIAL until the next Start.

## Timing
- Reset (reset_n=0, asynchronous):
  - state=INITIAL, so Q_Initial=1, Q_Play=0, Q_Lose=0
  - Score=0, High_Score=0, Score_Pulse=0, Hit_Mask=0, passed[]=0, hold counter=0
- Reset asserted mid-game aborts immediately. High_Score is lost.
- Inputs are sampled combinationally at each rising edge; all outputs are registered. Collision-to-Q_Lose latency and pass-to-Score latency are 1 cycle each.
- Start held high across a Lose→Initial transition starts a new game on the following edge, so INITIAL lasts exactly 1 cycle.
- Minimum LOSE dwell is LOSE_HOLD+1 cycles. With Ack held high, Q_Lose is high for exactly LOSE_HOLD+1 cycles.
- Score_Pulse is high for exactly 1 cycle per increment edge.

## Test plan
- Reset/start: reset_n low, then high; Start=1 for 1 cycle → Q_Play=1 one cycle later, Score=0, Hit_Mask=0.
- Pass scoring: pipe0 valid with X_Right stepping 120→99, Bird_X_L=100, bird in gap → Score 0→1 with a 1-cycle Score_Pulse. Hold X_Right=99 for 10 cycles → no further increment. Move it to 600, then back to 99 → Score=2.
- Multi-pass/saturation: SCORE_W=2, two pipes passing the bird on the same edge → Score +2. Continue passing → Score sticks at 3 while Score_Pulse still fires.
- Pipe collision: bird X 100–120, Y_T=50; pipe2 X 110–140 with gap 80–200 → Q_Lose on the next edge, Hit_Mask=0100, High_Score updated if Score exceeds it. Same geometry with Pipe_Valid[2]=0 → stays in PLAY.
- Collision/pass priority and boundary: a new pass plus a floor hit (Bird_Y_B=479) on one edge → LOSE, Score unchanged, Hit_Mask=0.
- Lose hold: LOSE_HOLD=20, Ack=1 from entry → Q_Initial exactly 21 cycles after entry. Ack pulsed only at cycle 5 → remains in LOSE. Drop reset_n during LOSE → immediate INITIAL with High_Score=0.
